// File: rtl/div_kh.sv
// Radix-2 restoring unsigned divider: one quotient bit per clock, start/ready/valid handshake.
// Latency DIVIDEND_W+1 cycles to the valid pulse (1 for divide-by-zero); start is ignored unless ready.
module div_kh #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  start_i,
   input  logic [DIVIDEND_W-1:0] dividend_i,
   input  logic [DIVISOR_W-1:0]  divisor_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [DIVIDEND_W-1:0] quotient_o,
   output logic [DIVISOR_W-1:0]  remainder_o,
   output logic                  div_by_zero_o
);

   localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DIVIDEND_W-1:0] shreg_q, shreg_d;
   logic [DIVISOR_W:0]    pr_q, pr_d;
   logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DIVIDEND_W-1:0] quo_q, quo_d;
   logic [DIVISOR_W-1:0]  rem_q, rem_d;
   logic                  dbz_q, dbz_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;

   // Partial remainder is one bit wider than the divisor so the compare never overflows.
   logic [DIVISOR_W:0]    pr_shift;
   logic [DIVISOR_W:0]    pr_sub;
   logic                  pr_ge;
   logic [DIVISOR_W:0]    pr_next;
   logic [DIVIDEND_W-1:0] shreg_next;

   always_comb begin
      pr_shift   = {pr_q[DIVISOR_W-1:0], shreg_q[DIVIDEND_W-1]};
      pr_sub     = pr_shift - {1'b0, dvs_q};
      pr_ge      = (pr_shift >= {1'b0, dvs_q});
      pr_next    = pr_ge ? pr_sub : pr_shift;
      shreg_next = {shreg_q[DIVIDEND_W-2:0], pr_ge};
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      pr_d    = pr_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (divisor_i != '0) begin
                  shreg_d = dividend_i;
                  dvs_d   = divisor_i;
                  pr_d    = '0;
                  cnt_d   = CNT_W'(DIVIDEND_W - 1);
                  dbz_d   = 1'b0;
                  state_d = S_CALC;
               end else begin
                  quo_d   = '1;
                  rem_d   = dividend_i[DIVISOR_W-1:0];
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_CALC: begin
            pr_d    = pr_next;
            shreg_d = shreg_next;
            if (cnt_q == '0) begin
               quo_d   = shreg_next;
               rem_d   = pr_next[DIVISOR_W-1:0];
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
         pr_q    <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         pr_q    <= pr_d;
         dvs_q   <= dvs_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   assign ready_o       = ready_q;
   assign valid_o       = valid_q;
   assign quotient_o    = quo_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_kh.sv
// Directed and random checks for div_kh: table vectors, handshake corners, reset abort, invariants.
module tb_div_kh;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] dividend;
   logic [7:0]  divisor;
   logic        ready;
   logic        valid;
   logic [15:0] quotient;
   logic [7:0]  remainder;
   logic        dbz;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [15:0] q;
      logic [7:0]  r;
      logic        dbz;
   } vec_t;

   vec_t vecs[10];

   div_kh #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .start_i       (start),
      .dividend_i    (dividend),
      .divisor_i     (divisor),
      .ready_o       (ready),
      .valid_o       (valid),
      .quotient_o    (quotient),
      .remainder_o   (remainder),
      .div_by_zero_o (dbz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Waits for ready, issues one request, then waits (bounded) for valid.
   // Returns the number of edges after the accepting edge at which valid was seen.
   task automatic launch(input logic [15:0] a, input logic [7:0] b, input int poke,
                         output int n, output logic rdy_seen);
      int w;
      w = 0;
      while (!ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      dividend = 16'hBEEF;
      divisor  = 8'h3C;
      n        = 0;
      rdy_seen = 1'b0;
      while (!valid && n < 40) begin
         if (ready) rdy_seen = 1'b1;
         if (n == poke) begin
            start    = 1'b1;
            dividend = 16'd50;
            divisor  = 8'd5;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v, input int poke);
      int   n;
      logic rs;
      launch(v.dvd, v.dvs, poke, n, rs);
      chk($sformatf("v%0d latency", idx), n, v.dbz ? 0 : 16);
      chk($sformatf("v%0d ready_low", idx), {31'd0, rs}, 0);
      chk($sformatf("v%0d quotient", idx), {16'd0, quotient}, {16'd0, v.q});
      chk($sformatf("v%0d remainder", idx), {24'd0, remainder}, {24'd0, v.r});
      chk($sformatf("v%0d dbz", idx), {31'd0, dbz}, {31'd0, v.dbz});
      @(negedge clk);
      chk($sformatf("v%0d valid_pulse", idx), {31'd0, valid}, 0);
      chk($sformatf("v%0d ready_back", idx), {31'd0, ready}, 1);
      chk($sformatf("v%0d q_hold", idx), {16'd0, quotient}, {16'd0, v.q});
   endtask

   initial begin
      int   n;
      logic rs;
      int   pulses;
      int   pos[4];
      int   w;
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rd;
      logic [7:0]  rv;

      vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
      vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
      vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
      vecs[3] = '{16'd5,     8'd10,  16'd0,     8'd5,   1'b0};
      vecs[4] = '{16'd0,     8'd3,   16'd0,     8'd0,   1'b0};
      vecs[5] = '{16'h04D2,  8'd0,   16'hFFFF,  8'hD2,  1'b1};
      vecs[6] = '{16'd100,   8'd3,   16'd33,    8'd1,   1'b0};
      vecs[7] = '{16'd12345, 8'd100, 16'd123,   8'd45,  1'b0};
      vecs[8] = '{16'd255,   8'd16,  16'd15,    8'd15,  1'b0};
      vecs[9] = '{16'd200,   8'd9,   16'd22,    8'd2,   1'b0};

      reset    = 1'b1;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", {31'd0, ready}, 1);
      chk("reset valid", {31'd0, valid}, 0);
      chk("reset quotient", {16'd0, quotient}, 0);
      chk("reset remainder", {24'd0, remainder}, 0);
      chk("reset dbz", {31'd0, dbz}, 0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i], -1);

      // A start pulse in the middle of CALC must not disturb the running division.
      run_vec(100, vecs[0], 5);

      // Start held high: one result every 18 cycles.
      pulses   = 0;
      start    = 1'b1;
      dividend = 16'd1000;
      divisor  = 8'd7;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid) begin
            if (pulses < 4) pos[pulses] = i;
            pulses++;
            chk("held quotient", {16'd0, quotient}, 32'd142);
         end
      end
      start = 1'b0;
      chk("held pulses", pulses, 3);
      chk("held pos0", pos[0], 16);
      chk("held pos1", pos[1], 34);
      chk("held pos2", pos[2], 52);
      w = 0;
      while (!(ready && !valid) && w < 40) begin
         @(negedge clk);
         w++;
      end
      chk("held drain", {31'd0, ready}, 1);

      // Reset on the edge of iteration 8 of 1000/7.
      start    = 1'b1;
      dividend = 16'd1000;
      divisor  = 8'd7;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort ready", {31'd0, ready}, 1);
      chk("abort valid", {31'd0, valid}, 0);
      chk("abort quotient", {16'd0, quotient}, 0);
      chk("abort remainder", {24'd0, remainder}, 0);
      chk("abort dbz", {31'd0, dbz}, 0);
      pulses = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (valid) pulses++;
      end
      chk("abort no_valid", pulses, 0);
      run_vec(200, vecs[9], -1);

      // Round trip against products of the 8x8 multiplier.
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(1, 255));
         launch(16'(ra * rb), rb, -1, n, rs);
         chk("rt latency", n, 16);
         chk("rt quotient", {16'd0, quotient}, {24'd0, ra});
         chk("rt remainder", {24'd0, remainder}, 0);
         @(negedge clk);
      end

      // Random pairs checked through the division identity.
      for (int i = 0; i < 1000; i++) begin
         rd = 16'($urandom_range(0, 65535));
         rv = 8'($urandom_range(1, 255));
         launch(rd, rv, -1, n, rs);
         chk("rnd latency", n, 16);
         chk("rnd identity", {16'd0, quotient} * {24'd0, rv} + {24'd0, remainder}, {16'd0, rd});
         chk("rnd rem_lt_div", {31'd0, (remainder < rv)}, 1);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_kh.md
Name: div_kh

Overview:
- Sequential unsigned divider: divides a 16-bit dividend by an 8-bit divisor and returns the quotient and remainder.
- Inverse partner of the 8x8 combinational multiplier (16-bit product) in the same arithmetic group. Any multiplier product C = A*B fed back with divisor B returns quotient A, remainder 0.
- Radix-2 restoring algorithm, one quotient bit per clock, with a start/ready/valid handshake.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width
- DIVISOR_W, 8, divisor and remainder width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- dividend  input  DIVIDEND_W  numerator, sampled on the accepting edge
- divisor  input  DIVISOR_W  denominator, sampled on the accepting edge
- ready  output  1  high in IDLE only
- valid  output  1  one-cycle pulse; results are valid while it is high
- quotient  output  DIVIDEND_W  result quotient
- remainder  output  DIVISOR_W  result remainder
- div_by_zero  output  1  set with valid when divisor was 0

Behaviour:
- Single clock domain, synchronous active-high reset. All outputs are registered.
- Reset values: state=IDLE, ready=1, valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: on an edge with start=1 and divisor!=0:
    - latch dividend into the shift register and divisor into its register;
    - clear the partial remainder (DIVISOR_W+1 bits);
    - count=DIVIDEND_W-1;
    - go to CALC.
  - IDLE: on an edge with start=1 and divisor==0:
    - quotient = all ones (16'hFFFF);
    - remainder = dividend[DIVISOR_W-1:0];
    - div_by_zero=1;
    - go to DONE.
  - CALC: each edge performs one iteration:
    - pr = {pr[DIVISOR_W-1:0], shreg MSB};
    - shift shreg left by one;
    - if pr >= divisor, subtract divisor from pr and shift in quotient bit 1; else shift in 0.
    - When count==0, this edge completes the last iteration: load quotient and remainder and go to DONE. Otherwise count decrements.
  - DONE: valid=1 for exactly this one cycle. The next edge returns to IDLE unconditionally.
- Latency:
  - Start accepted at edge k (normal path): valid is high in the cycle after edge k+DIVIDEND_W (16), and ready returns high after edge k+17. Throughput is one division per 18 cycles.
  - Divide by zero: valid is high in the cycle after edge k, and ready returns after edge k+1.
- div_by_zero is cleared to 0 on every accepted normal start and on reset.
- quotient, remainder and div_by_zero hold their values after valid falls, until the next accepted start updates them.
- start while ready=0 (CALC or DONE) is ignored, not queued. Dividend/divisor changes after acceptance have no effect.
- Holding start high continuously gives back-to-back operations: accepted in each IDLE cycle.
- Width rule: the partial-remainder comparison is DIVISOR_W+1 bits wide, so there is no overflow at divisor=255. The final remainder is always < divisor.
- Reset mid-CALC or in DONE: returns to IDLE next edge with all outputs at reset values, and no valid pulse is emitted.
- Invariant for every non-zero divisor: quotient*divisor + remainder == dividend, with remainder < divisor.

Test Plan:
- Basic division: dividend=1000, divisor=7 -> after 16 cycles, valid pulse, quotient=142, remainder=6, div_by_zero=0. ready low for 17 cycles.
- Boundary values:
  - 65535/255 -> q=257, r=0.
  - 65535/1 -> q=65535, r=0.
  - 5/10 -> q=0, r=5.
  - 0/3 -> q=0, r=0.
- Divide by zero: dividend=16'h04D2, divisor=0 -> valid one cycle after accept, quotient=16'hFFFF, remainder=8'hD2, div_by_zero=1. A following 100/3 gives q=33, r=1, div_by_zero=0.
- Handshake:
  - start pulsed during CALC with different operands -> ignored; first result unchanged.
  - start held high -> consecutive results every 18 cycles, with exactly one valid cycle each.
- Reset: assert reset at iteration 8 of 1000/7 -> next cycle ready=1, valid=0, outputs 0, no valid pulse. A fresh 200/9 then gives q=22, r=2.
- Round trip: random A,B (B!=0); feed C=A*B as dividend with divisor B -> quotient=A, remainder=0. Random 16/8-bit pairs check q*d+r==dividend and r<d (1000 iterations).
